// File: rtl/spi_cmd_router.sv
// SPI command router: decodes spi_slave packets, dispatches to clients, merges responses.
// Optional status command (0xFF) enabled by defining SPI_CMD_ROUTER_STATUS_EN.
module spi_cmd_router #(
  parameter int NUM_CLIENTS = 4,
  parameter int REQ_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      spi_rd_data_available,
  output logic                      spi_rd_ack,
  input  logic [23:0]               spi_rd_data,
  input  logic                      spi_wr_buffer_free,
  output logic                      spi_wr_en,
  output logic [15:0]               spi_wr_data,
  output logic [NUM_CLIENTS-1:0]    cl_req_valid,
  input  logic [NUM_CLIENTS-1:0]    cl_req_ready,
  output logic [3:0]                cl_req_sub,
  output logic [15:0]               cl_req_payload,
  input  logic [NUM_CLIENTS-1:0]    cl_rsp_valid,
  output logic [NUM_CLIENTS-1:0]    cl_rsp_ready,
  input  logic [16*NUM_CLIENTS-1:0] cl_rsp_data,
  output logic [7:0]                err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_DISPATCH
  } state_e;

  state_e                  state_q, state_d;
  logic [23:0]             pkt_q, pkt_d;
  logic                    ack_q, ack_d;
  logic                    ack_dly_q;
  logic [NUM_CLIENTS-1:0]  req_vld_q, req_vld_d;
  logic [7:0]              tmo_q, tmo_d;
  logic [7:0]              err_q, err_d;
  logic                    err_inc;

  logic [7:0]              cmd;
  logic [1:0]              idx;
  logic                    cmd_ok;

  assign cmd    = pkt_q[7:0];
  assign idx    = cmd[5:4];
  assign cmd_ok = (cmd[7:6] == 2'b00) &&
                  ({1'b0, idx} < 3'(NUM_CLIENTS));

  logic                    slot_busy;
  logic [15:0]             slot_data;
  logic                    slot_pop;

`ifdef SPI_CMD_ROUTER_STATUS_EN
  logic                    slot_full_q;
  logic [15:0]             slot_data_q;
  logic                    slot_push;
  logic                    is_stat;

  assign is_stat   = (cmd == 8'hFF);
  assign slot_busy = slot_full_q;
  assign slot_data = slot_data_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_full_q <= 1'b0;
      slot_data_q <= '0;
    end else if (slot_push) begin
      slot_full_q <= 1'b1;
      slot_data_q <= {8'hE5, err_q};
    end else if (slot_pop) begin
      slot_full_q <= 1'b0;
    end
  end
`else
  assign slot_busy = 1'b0;
  assign slot_data = '0;
`endif

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    ack_d     = 1'b0;
    req_vld_d = req_vld_q;
    tmo_d     = tmo_q;
    err_inc   = 1'b0;
`ifdef SPI_CMD_ROUTER_STATUS_EN
    slot_push = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        // ack_dly_q keeps acks 3 cycles apart while spi_slave pops
        if (spi_rd_data_available && !ack_dly_q) begin
          pkt_d   = spi_rd_data;
          ack_d   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
`ifdef SPI_CMD_ROUTER_STATUS_EN
        if (is_stat) begin
          if (!slot_full_q) begin
            slot_push = 1'b1;
            state_d   = S_IDLE;
          end
        end else
`endif
        if (cmd_ok) begin
          for (int i = 0; i < NUM_CLIENTS; i++) begin
            req_vld_d[i] = (idx == 2'(i));
          end
          tmo_d   = '0;
          state_d = S_DISPATCH;
        end else begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DISPATCH: begin
        if (|(req_vld_q & cl_req_ready)) begin
          req_vld_d = '0;
          state_d   = S_IDLE;
        end else if (tmo_q == 8'(REQ_TIMEOUT - 1)) begin
          req_vld_d = '0;
          err_inc   = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        req_vld_d = '0;
      end
    endcase
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pkt_q     <= '0;
      ack_q     <= 1'b0;
      ack_dly_q <= 1'b0;
      req_vld_q <= '0;
      tmo_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      ack_q     <= ack_d;
      ack_dly_q <= ack_q;
      req_vld_q <= req_vld_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
    end
  end

  logic [1:0]               ptr_q, ptr_d;
  logic                     hold_q, hold_d;
  logic                     wr_en_q, wr_en_d;
  logic [15:0]              wr_data_q, wr_data_d;
  logic [NUM_CLIENTS-1:0]   rsp_rdy_q, rsp_rdy_d;
  logic [2*NUM_CLIENTS-1:0] dbl;
  logic                     found;
  logic [1:0]               off;
  logic [2:0]               gsum;
  logic [1:0]               g;
  logic [15:0]              gdata;
  logic                     elig;

  always_comb begin
    dbl   = {cl_rsp_valid, cl_rsp_valid} >> ptr_q;
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        off   = 2'(k);
      end
    end
    gsum = {1'b0, ptr_q} + {1'b0, off};
    if (gsum >= 3'(NUM_CLIENTS)) begin
      gsum = gsum - 3'(NUM_CLIENTS);
    end
    g     = gsum[1:0];
    gdata = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (g == 2'(i)) begin
        gdata = cl_rsp_data[16*i +: 16];
      end
    end
  end

  assign elig = spi_wr_buffer_free && !hold_q && (found || slot_busy);

  always_comb begin
    wr_en_d   = 1'b0;
    wr_data_d = '0;
    rsp_rdy_d = '0;
    hold_d    = 1'b0;
    ptr_d     = ptr_q;
    slot_pop  = 1'b0;
    if (elig) begin
      wr_en_d = 1'b1;
      hold_d  = 1'b1;
      // the status slot outranks clients and leaves the pointer alone
      if (slot_busy) begin
        wr_data_d = slot_data;
        slot_pop  = 1'b1;
      end else begin
        wr_data_d = gdata;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
          rsp_rdy_d[i] = (g == 2'(i));
        end
        ptr_d = (g == 2'(NUM_CLIENTS - 1)) ? 2'd0 : g + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q     <= '0;
      hold_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      rsp_rdy_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rsp_rdy_q <= rsp_rdy_d;
    end
  end

  assign spi_rd_ack     = ack_q;
  assign spi_wr_en      = wr_en_q;
  assign spi_wr_data    = wr_data_q;
  assign cl_req_valid   = req_vld_q;
  assign cl_req_sub     = pkt_q[3:0];
  assign cl_req_payload = pkt_q[23:8];
  assign cl_rsp_ready   = rsp_rdy_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_spi_cmd_router.sv
// Directed bench for spi_cmd_router: 4-client/timeout-8 instance plus a 3-client instance.
// Status-command checks are built when SPI_CMD_ROUTER_STATUS_EN is defined.
module tb_spi_cmd_router;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        avail;
  logic [23:0] rd_data;
  logic        free;
  logic [3:0]  cl_ready;
  logic [3:0]  rsp_valid;
  logic [63:0] rsp_data;

  logic        ack, wr_en;
  logic [15:0] wr_data;
  logic [3:0]  req_valid;
  logic [3:0]  sub;
  logic [15:0] payload;
  logic [3:0]  rsp_ready;
  logic [7:0]  err;

  logic [2:0]  rsp_valid3;
  logic [47:0] rsp_data3;
  logic        ack3, wr_en3;
  logic [15:0] wr_data3;
  logic [2:0]  req_valid3;
  logic [3:0]  sub3;
  logic [15:0] payload3;
  logic [2:0]  rsp_ready3;
  logic [7:0]  err3;

  spi_cmd_router #(.NUM_CLIENTS(4), .REQ_TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_rd_data_available(avail), .spi_rd_ack(ack),
    .spi_rd_data(rd_data), .spi_wr_buffer_free(free),
    .spi_wr_en(wr_en), .spi_wr_data(wr_data),
    .cl_req_valid(req_valid), .cl_req_ready(cl_ready),
    .cl_req_sub(sub), .cl_req_payload(payload),
    .cl_rsp_valid(rsp_valid), .cl_rsp_ready(rsp_ready),
    .cl_rsp_data(rsp_data), .err_count(err)
  );

  spi_cmd_router #(.NUM_CLIENTS(3), .REQ_TIMEOUT(255)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .spi_rd_data_available(avail), .spi_rd_ack(ack3),
    .spi_rd_data(rd_data), .spi_wr_buffer_free(free),
    .spi_wr_en(wr_en3), .spi_wr_data(wr_data3),
    .cl_req_valid(req_valid3), .cl_req_ready(cl_ready[2:0]),
    .cl_req_sub(sub3), .cl_req_payload(payload3),
    .cl_rsp_valid(rsp_valid3), .cl_rsp_ready(rsp_ready3),
    .cl_rsp_data(rsp_data3), .err_count(err3)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [23:0] d);
    rd_data = d;
    avail   = 1'b1;
    @(negedge clk);
    avail   = 1'b0;
  endtask

  logic [15:0] expd [3];
  logic [3:0]  expr [3];
  logic [3:0]  ackbits;
  int          cnt, k, nwr;

  initial begin
    expd = '{16'h1111, 16'h3333, 16'h4444};
    expr = '{4'b0001, 4'b0100, 4'b1000};
    reset_n = 1'b0; avail = 1'b0; rd_data = '0; free = 1'b0;
    cl_ready = '0; rsp_valid = '0; rsp_valid3 = '0; rsp_data3 = '0;
    rsp_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_rsp_ready", rsp_ready, 0);
    chk("rst_err", err, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // dispatch to client 1, ready immediately
    cl_ready = 4'b0010;
    send(24'h00AB12);
    chk("t1_ack", ack, 1);
    chk("t1_valid_early", req_valid, 0);
    @(negedge clk);
    chk("t1_valid", req_valid, 4'b0010);
    chk("t1_sub", sub, 4'h2);
    chk("t1_payload", payload, 16'h00AB);
    chk("t1_ack_pulse", ack, 0);
    chk("t1_valid3", req_valid3, 3'b010);
    @(negedge clk);
    chk("t1_valid_drop", req_valid, 0);
    repeat (3) @(negedge clk);

    // malformed and out-of-range commands
    cl_ready = 4'b1000;
    send(24'h000040);
    chk("t2_ack40", ack, 1);
    @(negedge clk);
    chk("t2_err", err, 1);
    chk("t2_err3", err3, 1);
    chk("t2_novalid", req_valid, 0);
    repeat (3) @(negedge clk);
    send(24'h000030);
    chk("t2_ack30", ack3, 1);
    @(negedge clk);
    chk("t2_valid_c3", req_valid, 4'b1000);
    chk("t2_novalid3", req_valid3, 0);
    chk("t2_err3_b", err3, 2);
    chk("t2_err_b", err, 1);
    @(negedge clk);
    chk("t2_valid_drop", req_valid, 0);
    repeat (2) @(negedge clk);

    // continuous availability: acks 3 cycles apart
    rd_data = 24'h000080;
    avail   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ackbits[i] = ack;
    end
    avail = 1'b0;
    chk("t3_ack_gap", ackbits, 4'b1001);
    repeat (2) @(negedge clk);
    chk("t3_err", err, 3);
    chk("t3_err3", err3, 4);
    repeat (2) @(negedge clk);

    // request timeout
    cl_ready = '0;
    send(24'h123401);
    chk("t4_ack", ack, 1);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) chk("t4_payload", payload, 16'h1234);
      if (req_valid[0]) cnt++;
    end
    chk("t4_valid_cycles", cnt, 8);
    chk("t4_err", err, 4);
    cl_ready = 4'b0010;
    send(24'h000010);
    chk("t4_next_ack", ack, 1);
    @(negedge clk);
    chk("t4_next_valid", req_valid, 4'b0010);
    @(negedge clk);

    // round-robin responses
    free = 1'b1;
    rsp_valid = 4'b1101;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (wr_en) begin
        if (k < 3) begin
          chk("t5_data", wr_data, expd[k]);
          chk("t5_ready", rsp_ready, expr[k]);
          chk("t5_slot", i, 2 * k + 1);
        end
        rsp_valid = rsp_valid & ~rsp_ready;
        k++;
      end
    end
    chk("t5_nwr", k, 3);
    rsp_valid = 4'b0011;
    @(negedge clk);
    chk("t6_ptr_wr", wr_en, 1);
    chk("t6_ptr_data", wr_data, 16'h1111);
    chk("t6_ptr_ready", rsp_ready, 4'b0001);
    rsp_valid = '0;
    repeat (2) @(negedge clk);

    // buffer full backpressure
    free = 1'b0;
    rsp_valid = 4'b0010;
    nwr = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr_en) nwr++;
    end
    chk("t7_blocked", nwr, 0);
    free = 1'b1;
    @(negedge clk);
    chk("t7_wr", wr_en, 1);
    chk("t7_data", wr_data, 16'h2222);
    chk("t7_ready", rsp_ready, 4'b0010);
    rsp_valid = '0;
    @(negedge clk);
    chk("t7_wr_pulse", wr_en, 0);

`ifdef SPI_CMD_ROUTER_STATUS_EN
    free = 1'b0;
    rsp_valid = 4'b0100;
    send(24'h0000FF);
    chk("t8_ack", ack, 1);
    @(negedge clk);
    chk("t8_err", err, 4);
    chk("t8_novalid", req_valid, 0);
    free = 1'b1;
    @(negedge clk);
    chk("t8_stat_wr", wr_en, 1);
    chk("t8_stat_data", wr_data, 16'hE504);
    chk("t8_stat_ready", rsp_ready, 0);
    @(negedge clk);
    chk("t8_gap", wr_en, 0);
    @(negedge clk);
    chk("t8_c2_wr", wr_en, 1);
    chk("t8_c2_data", wr_data, 16'h3333);
    chk("t8_c2_ready", rsp_ready, 4'b0100);
    rsp_valid = '0;
    chk("t8_err_keep", err, 4);
`else
    send(24'h0000FF);
    chk("t8_ack", ack, 1);
    @(negedge clk);
    chk("t8_err_ff", err, 5);
    chk("t8_novalid", req_valid, 0);
`endif
    repeat (2) @(negedge clk);

    // saturation of the error counter
    rd_data = 24'h000040;
    avail   = 1'b1;
    repeat (800) @(negedge clk);
    avail = 1'b0;
    repeat (4) @(negedge clk);
    chk("t9_err_sat", err, 8'hFF);

    // reset while dispatching
    cl_ready = '0;
    send(24'h000001);
    @(negedge clk);
    chk("t10_valid", req_valid, 4'b0001);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t10_rst_valid", req_valid, 0);
    chk("t10_rst_err", err, 0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
